uc_arbiter: RTL and testbench
=============================

# uc_arbiter

Unit-clause arbiter for the multi-PE BCP array. It drains implications from every PE's `UCQ_in` queue in round-robin order and checks each literal against a global variable-assignment table. Each new literal is broadcast into every PE's `UCQ_out` queue. A duplicate is dropped; an opposite-polarity hit raises a sticky conflict. It is the consumer end of each PE's `UCQ_in` and the producer end of each PE's `UCQ_out`.

## Interface
Parameters:
- `NUM_PE`, 4: number of BCP PEs served.
- `LIT_W`, 16: literal width; equals `LIT_IDX_MAX*2`; two's-complement signed.
- `NUM_VARS`, 256: variable table size; variable index = |lit|, range 1..NUM_VARS-1.

Ports:
- `clk`  in  1  single clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `flush`  in  1  synchronous clear of table, conflict and FSM (restart/backtrack).
- `UCQ_in_empty`  in  NUM_PE  per-PE `UCQ_in` empty.
- `UCQ_in2uarb_uc`  in  NUM_PE×LIT_W  per-PE `UCQ_in` head literal; valid while not empty.
- `ucarb2UCQ_in_pop`  out  NUM_PE  one-hot pop; at most one bit set per cycle.
- `UCQ_out_full`  in  NUM_PE  per-PE `UCQ_out` full.
- `ucarb2UCQ_out_push`  out  NUM_PE  broadcast push; all bits equal.
- `ucarb2UCQ_out_uc`  out  LIT_W  broadcast literal, shared by all PEs.
- `conflict`  out  1  sticky; complementary literals seen.
- `busy`  out  1  FSM not in IDLE, or any `UCQ_in` non-empty.
- `bcast_cnt`  out  16  literals broadcast; saturating.
- `drop_cnt`  out  16  duplicates plus zero literals dropped; saturating.

## Operation
State:
- `lit_reg`: latched literal.
- `rr_ptr`: round-robin pointer, log2(NUM_PE) bits.
- `assigned[NUM_VARS]` and `polarity[NUM_VARS]` flop arrays.
- Counters.

FSM:
- **IDLE**
  - If `flush`, stay.
  - Else, if any `UCQ_in_empty[i]==0`, grant the first non-empty PE searching from `rr_ptr` upward with wrap.
  - In that same cycle, assert `ucarb2UCQ_in_pop[g]`, latch `UCQ_in2uarb_uc[g]` into `lit_reg`, set `rr_ptr <= (g+1) mod NUM_PE`, and go to CHECK.
- **CHECK** (combinational table read on v = |lit_reg|)
  - `lit_reg==0`: increment `drop_cnt` and go to IDLE.
  - `assigned[v]==0`: set `assigned[v]=1` and `polarity[v]=(lit_reg>0)`, then go to BCAST.
  - `assigned[v]==1` and the polarity matches: increment `drop_cnt` and go to IDLE.
  - `assigned[v]==1` and the polarity differs: set `conflict=1` and go to CONFLICT.
- **BCAST**
  - Wait while any `UCQ_out_full[i]==1`.
  - Otherwise, for one cycle, assert all `ucarb2UCQ_out_push` bits, drive `ucarb2UCQ_out_uc=lit_reg`, increment `bcast_cnt`, and go to IDLE.
  - The originating PE also receives the literal.
- **CONFLICT**
  - No pops, no pushes.
  - Remain here until `flush`.

Flush and arithmetic rules:
- `flush` is checked in any state and has top priority.
  - It clears `assigned`, `polarity` and `conflict`, and moves the FSM to IDLE.
  - It discards `lit_reg`.
  - It issues no pop or push in that cycle.
  - It does not clear the counters.
- |lit| is computed in two's complement. The most-negative value is not produced by PEs and is treated as `lit_reg==0` (dropped).
- A variable index ≥ NUM_VARS is dropped and counted in `drop_cnt`.
- Counters saturate at 0xFFFF.

## Timing
- Reset values: `ucarb2UCQ_in_pop=0`, `ucarb2UCQ_out_push=0`, `ucarb2UCQ_out_uc=0`, `conflict=0`, `bcast_cnt=0`, `drop_cnt=0`, `rr_ptr=0`, table cleared, FSM=IDLE.
- `busy` reflects inputs combinationally.
- Pop is combinational from `UCQ_in_empty` and the FSM state. It is never asserted to an empty queue.
- Minimum cost per literal: 3 cycles for a new literal (pop, check, push) with no back-pressure; 2 cycles for a drop.
- Push occurs in the cycle BCAST sees all `UCQ_out_full==0`. Latency from pop to push is ≥2 cycles.
- `ucarb2UCQ_out_uc` holds `lit_reg` during BCAST and 0 otherwise.
- `conflict` rises in the cycle after CHECK detects the clash and stays high until the cycle after `flush`.
- Reset asserted mid-operation returns all state to reset values asynchronously. A literal already popped is lost.

## Test plan
- PE0 pushes +5, all others empty → pop PE0 in cycle 0; push to all PEs in cycle 2 with uc=+5; `bcast_cnt=1`.
- PE1 and PE3 each hold +7 in the same cycle, `rr_ptr=0` → PE1 popped first and broadcast; PE3's +7 is dropped; `drop_cnt=1`, `bcast_cnt=1`, `rr_ptr=0` afterwards.
- PE2 gives +9, then PE0 gives −9 → second CHECK sets `conflict=1`; no further pops while PEs 0–3 stay non-empty; `flush` → `conflict=0`; −9 resubmitted is broadcast.
- PE0 gives +3 with `UCQ_out_full[2]=1` for 4 cycles → no push during those cycles; push occurs in the first cycle all full bits are 0; a new `UCQ_in` entry is not popped meanwhile.
- All 4 PEs continuously supply distinct literals → grants rotate 0,1,2,3,0; each gets ≤1 pop per 3 cycles; no starvation over 40 cycles.
- Assert `rst_n=0` during BCAST → push drops immediately; counters and table read zero; `assigned[v]` of the lost literal is 0.

Source files
------------

// File: rtl/uc_arbiter_if.sv
// Unit-clause arbiter queue bundle: per-PE UCQ_in consumer side and UCQ_out producer side.
// master = arbiter, slave = PE-side queues.
interface uc_arbiter_if #(
   parameter int NUM_PE = 4,
   parameter int LIT_W  = 16
);
   logic [NUM_PE-1:0]             UCQ_in_empty;
   logic [NUM_PE-1:0][LIT_W-1:0]  UCQ_in2uarb_uc;
   logic [NUM_PE-1:0]             ucarb2UCQ_in_pop;
   logic [NUM_PE-1:0]             UCQ_out_full;
   logic [NUM_PE-1:0]             ucarb2UCQ_out_push;
   logic [LIT_W-1:0]              ucarb2UCQ_out_uc;

   modport master (
      input  UCQ_in_empty, UCQ_in2uarb_uc, UCQ_out_full,
      output ucarb2UCQ_in_pop, ucarb2UCQ_out_push, ucarb2UCQ_out_uc
   );

   modport slave (
      output UCQ_in_empty, UCQ_in2uarb_uc, UCQ_out_full,
      input  ucarb2UCQ_in_pop, ucarb2UCQ_out_push, ucarb2UCQ_out_uc
   );
endinterface

// File: rtl/uc_arbiter.sv
// Unit-clause arbiter: round-robin drain of PE UCQ_in queues, assignment-table
// check, broadcast of new literals to every UCQ_out, sticky conflict on a clash.
//
// state      | meaning
// S_IDLE     | search for a non-empty UCQ_in, pop and latch its head
// S_CHECK    | look up |lit_reg| in the assignment table
// S_BCAST    | push lit_reg to all UCQ_out once none is full
// S_CONFLICT | complementary literal seen; frozen until flush
module uc_arbiter #(
   parameter int NUM_PE   = 4,
   parameter int LIT_W    = 16,
   parameter int NUM_VARS = 256
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          flush,
   uc_arbiter_if.master  ucq,
   output logic          conflict,
   output logic          busy,
   output logic [15:0]   bcast_cnt,
   output logic [15:0]   drop_cnt
);
   localparam int RR_W   = (NUM_PE > 1) ? $clog2(NUM_PE) : 1;
   localparam int VIDX_W = $clog2(NUM_VARS);
   localparam logic [LIT_W-1:0] VARS_LIM = LIT_W'(NUM_VARS);

   typedef enum logic [1:0] {S_IDLE, S_CHECK, S_BCAST, S_CONFLICT} state_t;

   state_t               state, state_nxt;
   logic [LIT_W-1:0]     lit_reg;
   logic [RR_W-1:0]      rr_ptr, grant, rr_nxt;
   logic                 any_req;
   logic [NUM_VARS-1:0]  assigned, polarity;
   logic [LIT_W-1:0]     lit_abs;
   logic [VIDX_W-1:0]    v_idx;
   logic                 lit_bad, lit_pos;
   logic                 load_lit, tbl_wr, set_conflict, inc_bcast, inc_drop;

   // Most-negative literal has abs with MSB set and falls into lit_bad.
   always_comb begin
      lit_abs = lit_reg[LIT_W-1] ? (LIT_W'(0) - lit_reg) : lit_reg;
      lit_pos = ~lit_reg[LIT_W-1];
      v_idx   = lit_abs[VIDX_W-1:0];
      lit_bad = (lit_abs == '0) || lit_abs[LIT_W-1] || (lit_abs >= VARS_LIM);
   end

   // Scan downward so the closest non-empty queue at or above rr_ptr wins.
   always_comb begin
      grant   = '0;
      any_req = 1'b0;
      for (int k = NUM_PE - 1; k >= 0; k--) begin
         if (!ucq.UCQ_in_empty[(int'(rr_ptr) + k) % NUM_PE]) begin
            grant   = RR_W'((int'(rr_ptr) + k) % NUM_PE);
            any_req = 1'b1;
         end
      end
      rr_nxt = (grant == RR_W'(NUM_PE - 1)) ? '0 : grant + RR_W'(1);
   end

   always_comb begin
      state_nxt              = state;
      ucq.ucarb2UCQ_in_pop   = '0;
      ucq.ucarb2UCQ_out_push = '0;
      ucq.ucarb2UCQ_out_uc   = (state == S_BCAST) ? lit_reg : '0;
      load_lit               = 1'b0;
      tbl_wr                 = 1'b0;
      set_conflict           = 1'b0;
      inc_bcast              = 1'b0;
      inc_drop               = 1'b0;
      if (flush) begin
         state_nxt = S_IDLE;
      end else begin
         case (state)
            S_IDLE: begin
               if (any_req) begin
                  ucq.ucarb2UCQ_in_pop[grant] = 1'b1;
                  load_lit                    = 1'b1;
                  state_nxt                   = S_CHECK;
               end
            end
            S_CHECK: begin
               if (lit_bad) begin
                  inc_drop  = 1'b1;
                  state_nxt = S_IDLE;
               end else if (!assigned[v_idx]) begin
                  tbl_wr    = 1'b1;
                  state_nxt = S_BCAST;
               end else if (polarity[v_idx] == lit_pos) begin
                  inc_drop  = 1'b1;
                  state_nxt = S_IDLE;
               end else begin
                  set_conflict = 1'b1;
                  state_nxt    = S_CONFLICT;
               end
            end
            S_BCAST: begin
               if (~|ucq.UCQ_out_full) begin
                  ucq.ucarb2UCQ_out_push = '1;
                  inc_bcast              = 1'b1;
                  state_nxt              = S_IDLE;
               end
            end
            default: state_nxt = S_CONFLICT;
         endcase
      end
   end

   assign busy = (state != S_IDLE) || !(&ucq.UCQ_in_empty);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= S_IDLE;
         lit_reg   <= '0;
         rr_ptr    <= '0;
         assigned  <= '0;
         polarity  <= '0;
         conflict  <= 1'b0;
         bcast_cnt <= '0;
         drop_cnt  <= '0;
      end else begin
         state <= state_nxt;
         if (load_lit) begin
            lit_reg <= ucq.UCQ_in2uarb_uc[grant];
            rr_ptr  <= rr_nxt;
         end
         if (tbl_wr) begin
            assigned[v_idx] <= 1'b1;
            polarity[v_idx] <= lit_pos;
         end
         if (set_conflict) conflict <= 1'b1;
         if (inc_bcast && (bcast_cnt != 16'hFFFF)) bcast_cnt <= bcast_cnt + 16'd1;
         if (inc_drop && (drop_cnt != 16'hFFFF)) drop_cnt <= drop_cnt + 16'd1;
         // Counters deliberately survive a flush; only the search state is restarted.
         if (flush) begin
            lit_reg  <= '0;
            assigned <= '0;
            polarity <= '0;
            conflict <= 1'b0;
         end
      end
   end
endmodule

// File: tb/tb_uc_arbiter.sv
// Directed bench for uc_arbiter with a small per-PE UCQ_in FIFO model.
module tb_uc_arbiter;
   localparam int NUM_PE   = 4;
   localparam int LIT_W    = 16;
   localparam int NUM_VARS = 256;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        flush = 1'b0;
   logic [3:0]  out_full = 4'b0000;
   logic        conflict, busy;
   logic [15:0] bcast_cnt, drop_cnt;

   int checks = 0;
   int fails  = 0;

   uc_arbiter_if #(.NUM_PE(NUM_PE), .LIT_W(LIT_W)) ucq ();

   uc_arbiter #(.NUM_PE(NUM_PE), .LIT_W(LIT_W), .NUM_VARS(NUM_VARS)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (flush),
      .ucq       (ucq),
      .conflict  (conflict),
      .busy      (busy),
      .bcast_cnt (bcast_cnt),
      .drop_cnt  (drop_cnt)
   );

   always #5 clk = ~clk;

   logic [15:0] mem [NUM_PE][64];
   logic [5:0]  wr_ptr [NUM_PE] = '{default: 6'd0};
   logic [5:0]  rd_ptr [NUM_PE] = '{default: 6'd0};

   always_comb begin
      ucq.UCQ_in_empty   = '1;
      ucq.UCQ_in2uarb_uc = '0;
      for (int i = 0; i < NUM_PE; i++) begin
         ucq.UCQ_in_empty[i] = (rd_ptr[i] == wr_ptr[i]);
         if (rd_ptr[i] != wr_ptr[i]) ucq.UCQ_in2uarb_uc[i] = mem[i][rd_ptr[i]];
      end
   end
   assign ucq.UCQ_out_full = out_full;

   int          cyc = 0;
   int          pop_n = 0;
   int          pop_pe [256];
   int          pop_cyc [256];
   int          push_n = 0;
   logic [15:0] push_lit [256];

   always @(posedge clk) begin
      cyc = cyc + 1;
      for (int i = 0; i < NUM_PE; i++) begin
         if (ucq.ucarb2UCQ_in_pop[i]) begin
            if (ucq.UCQ_in_empty[i]) begin
               checks++; fails++;
               $display("FAIL pop_empty: pe %0d popped while empty=1, required no pop", i);
            end else begin
               rd_ptr[i] <= rd_ptr[i] + 6'd1;
            end
            pop_pe[pop_n]  = i;
            pop_cyc[pop_n] = cyc;
            pop_n          = pop_n + 1;
         end
      end
      if (|ucq.ucarb2UCQ_out_push) begin
         push_lit[push_n] = ucq.ucarb2UCQ_out_uc;
         push_n           = push_n + 1;
      end
   end

   task automatic add_lit(input int pe, input logic [15:0] lit);
      mem[pe][wr_ptr[pe]] = lit;
      wr_ptr[pe]          = wr_ptr[pe] + 6'd1;
   endtask

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   task automatic wait_idle(input string name);
      int n = 0;
      #1;
      while (busy !== 1'b0 && n < 100) begin
         step();
         n++;
      end
      checks++;
      if (busy !== 1'b0) begin
         fails++;
         $display("FAIL %s_idle_timeout: busy=%b after %0d cycles, required 0", name, busy, n);
      end
   endtask

   task automatic test_reset();
      step();
      checks++; if (ucq.ucarb2UCQ_in_pop !== 4'b0000) begin fails++; $display("FAIL rst_pop: got %b want 0000", ucq.ucarb2UCQ_in_pop); end
      checks++; if (ucq.ucarb2UCQ_out_push !== 4'b0000) begin fails++; $display("FAIL rst_push: got %b want 0000", ucq.ucarb2UCQ_out_push); end
      checks++; if (ucq.ucarb2UCQ_out_uc !== 16'h0000) begin fails++; $display("FAIL rst_uc: got %h want 0000", ucq.ucarb2UCQ_out_uc); end
      checks++; if (conflict !== 1'b0) begin fails++; $display("FAIL rst_conflict: got %b want 0", conflict); end
      checks++; if (bcast_cnt !== 16'd0) begin fails++; $display("FAIL rst_bcast: got %0d want 0", bcast_cnt); end
      checks++; if (drop_cnt !== 16'd0) begin fails++; $display("FAIL rst_drop: got %0d want 0", drop_cnt); end
      checks++; if (busy !== 1'b0) begin fails++; $display("FAIL rst_busy: got %b want 0", busy); end
      rst_n = 1'b1;
      step();
   endtask

   task automatic test_single();
      add_lit(0, 16'd5);
      #1;
      checks++; if (ucq.ucarb2UCQ_in_pop !== 4'b0001) begin fails++; $display("FAIL single_pop: got %b want 0001", ucq.ucarb2UCQ_in_pop); end
      checks++; if (busy !== 1'b1) begin fails++; $display("FAIL single_busy: got %b want 1", busy); end
      step();
      checks++; if (ucq.ucarb2UCQ_in_pop !== 4'b0000) begin fails++; $display("FAIL single_check_pop: got %b want 0000", ucq.ucarb2UCQ_in_pop); end
      checks++; if (ucq.ucarb2UCQ_out_push !== 4'b0000) begin fails++; $display("FAIL single_check_push: got %b want 0000", ucq.ucarb2UCQ_out_push); end
      step();
      checks++; if (ucq.ucarb2UCQ_out_push !== 4'b1111) begin fails++; $display("FAIL single_push: got %b want 1111", ucq.ucarb2UCQ_out_push); end
      checks++; if (ucq.ucarb2UCQ_out_uc !== 16'd5) begin fails++; $display("FAIL single_uc: got %0d want 5", $signed(ucq.ucarb2UCQ_out_uc)); end
      step();
      checks++; if (ucq.ucarb2UCQ_out_push !== 4'b0000) begin fails++; $display("FAIL single_push_end: got %b want 0000", ucq.ucarb2UCQ_out_push); end
      checks++; if (ucq.ucarb2UCQ_out_uc !== 16'd0) begin fails++; $display("FAIL single_uc_idle: got %h want 0000", ucq.ucarb2UCQ_out_uc); end
      checks++; if (bcast_cnt !== 16'd1) begin fails++; $display("FAIL single_bcast: got %0d want 1", bcast_cnt); end
      checks++; if (busy !== 1'b0) begin fails++; $display("FAIL single_busy_end: got %b want 0", busy); end
   endtask

   task automatic test_dup_rr();
      add_lit(1, 16'd7);
      add_lit(3, 16'd7);
      #1;
      checks++; if (ucq.ucarb2UCQ_in_pop !== 4'b0010) begin fails++; $display("FAIL dup_first_pop: got %b want 0010", ucq.ucarb2UCQ_in_pop); end
      step();
      step();
      checks++; if (ucq.ucarb2UCQ_out_push !== 4'b1111 || ucq.ucarb2UCQ_out_uc !== 16'd7) begin fails++; $display("FAIL dup_bcast: push %b uc %0d want 1111 / 7", ucq.ucarb2UCQ_out_push, ucq.ucarb2UCQ_out_uc); end
      step();
      checks++; if (ucq.ucarb2UCQ_in_pop !== 4'b1000) begin fails++; $display("FAIL dup_second_pop: got %b want 1000", ucq.ucarb2UCQ_in_pop); end
      step();
      checks++; if (ucq.ucarb2UCQ_out_push !== 4'b0000) begin fails++; $display("FAIL dup_no_push: got %b want 0000", ucq.ucarb2UCQ_out_push); end
      step();
      checks++; if (busy !== 1'b0) begin fails++; $display("FAIL dup_drop_2cyc: busy %b want 0", busy); end
      checks++; if (drop_cnt !== 16'd1) begin fails++; $display("FAIL dup_drop_cnt: got %0d want 1", drop_cnt); end
      checks++; if (bcast_cnt !== 16'd2) begin fails++; $display("FAIL dup_bcast_cnt: got %0d want 2", bcast_cnt); end
      // rr_ptr should have wrapped to 0: PE0 beats PE3.
      add_lit(0, 16'd11);
      add_lit(3, 16'd12);
      #1;
      checks++; if (ucq.ucarb2UCQ_in_pop !== 4'b0001) begin fails++; $display("FAIL rr_wrap_pop: got %b want 0001", ucq.ucarb2UCQ_in_pop); end
      wait_idle("rr_wrap");
      checks++; if (push_lit[push_n-2] !== 16'd11 || push_lit[push_n-1] !== 16'd12) begin fails++; $display("FAIL rr_wrap_order: got %0d,%0d want 11,12", push_lit[push_n-2], push_lit[push_n-1]); end
      checks++; if (bcast_cnt !== 16'd4) begin fails++; $display("FAIL rr_wrap_bcast: got %0d want 4", bcast_cnt); end
   endtask

   task automatic test_conflict();
      add_lit(2, 16'd9);
      wait_idle("conf_pos");
      add_lit(0, -16'sd9);
      #1;
      checks++; if (ucq.ucarb2UCQ_in_pop !== 4'b0001) begin fails++; $display("FAIL conf_pop: got %b want 0001", ucq.ucarb2UCQ_in_pop); end
      step();
      checks++; if (conflict !== 1'b0) begin fails++; $display("FAIL conf_early: got %b want 0", conflict); end
      add_lit(1, 16'd20);
      add_lit(2, 16'd21);
      add_lit(3, 16'd22);
      step();
      checks++; if (conflict !== 1'b1) begin fails++; $display("FAIL conf_rise: got %b want 1", conflict); end
      for (int k = 0; k < 3; k++) begin
         checks++; if (ucq.ucarb2UCQ_in_pop !== 4'b0000 || ucq.ucarb2UCQ_out_push !== 4'b0000) begin fails++; $display("FAIL conf_frozen%0d: pop %b push %b want 0000/0000", k, ucq.ucarb2UCQ_in_pop, ucq.ucarb2UCQ_out_push); end
         step();
      end
      flush = 1'b1;
      #1;
      checks++; if (conflict !== 1'b1 || ucq.ucarb2UCQ_in_pop !== 4'b0000) begin fails++; $display("FAIL conf_flush_cycle: conflict %b pop %b want 1/0000", conflict, ucq.ucarb2UCQ_in_pop); end
      step();
      flush = 1'b0;
      #1;
      checks++; if (conflict !== 1'b0) begin fails++; $display("FAIL conf_cleared: got %b want 0", conflict); end
      checks++; if (ucq.ucarb2UCQ_in_pop !== 4'b0010) begin fails++; $display("FAIL conf_resume_pop: got %b want 0010", ucq.ucarb2UCQ_in_pop); end
      wait_idle("conf_drain");
      add_lit(0, -16'sd9);
      wait_idle("conf_resubmit");
      checks++; if (push_lit[push_n-1] !== 16'hFFF7) begin fails++; $display("FAIL conf_resubmit_uc: got %h want fff7", push_lit[push_n-1]); end
      checks++; if (bcast_cnt !== 16'd9 || drop_cnt !== 16'd1) begin fails++; $display("FAIL conf_counts: bcast %0d drop %0d want 9/1", bcast_cnt, drop_cnt); end
      checks++; if (conflict !== 1'b0) begin fails++; $display("FAIL conf_after: got %b want 0", conflict); end
   endtask

   task automatic test_backpressure();
      out_full = 4'b0100;
      add_lit(0, 16'd3);
      #1;
      checks++; if (ucq.ucarb2UCQ_in_pop !== 4'b0001) begin fails++; $display("FAIL bp_pop: got %b want 0001", ucq.ucarb2UCQ_in_pop); end
      step();
      step();
      add_lit(1, 16'd30);
      #1;
      for (int k = 0; k < 2; k++) begin
         checks++; if (ucq.ucarb2UCQ_out_push !== 4'b0000 || ucq.ucarb2UCQ_in_pop !== 4'b0000) begin fails++; $display("FAIL bp_hold%0d: push %b pop %b want 0000/0000", k, ucq.ucarb2UCQ_out_push, ucq.ucarb2UCQ_in_pop); end
         checks++; if (ucq.ucarb2UCQ_out_uc !== 16'd3) begin fails++; $display("FAIL bp_uc_hold%0d: got %0d want 3", k, ucq.ucarb2UCQ_out_uc); end
         step();
      end
      out_full = 4'b0000;
      #1;
      checks++; if (ucq.ucarb2UCQ_out_push !== 4'b1111 || ucq.ucarb2UCQ_out_uc !== 16'd3) begin fails++; $display("FAIL bp_release: push %b uc %0d want 1111/3", ucq.ucarb2UCQ_out_push, ucq.ucarb2UCQ_out_uc); end
      step();
      checks++; if (ucq.ucarb2UCQ_in_pop !== 4'b0010) begin fails++; $display("FAIL bp_next_pop: got %b want 0010", ucq.ucarb2UCQ_in_pop); end
      wait_idle("bp");
      checks++; if (bcast_cnt !== 16'd11) begin fails++; $display("FAIL bp_bcast: got %0d want 11", bcast_cnt); end
   endtask

   task automatic test_rotation();
      int p0, q0;
      add_lit(3, 16'd60);
      wait_idle("rot_align");
      p0 = pop_n;
      q0 = push_n;
      for (int j = 0; j < 3; j++)
         for (int i = 0; i < NUM_PE; i++)
            add_lit(i, 16'(40 + 4*j + i));
      wait_idle("rot");
      checks++; if (pop_n - p0 != 12) begin fails++; $display("FAIL rot_pop_count: got %0d want 12", pop_n - p0); end
      for (int k = 0; k < 12 && p0 + k < pop_n; k++) begin
         checks++; if (pop_pe[p0+k] != k % 4) begin fails++; $display("FAIL rot_grant%0d: got pe %0d want %0d", k, pop_pe[p0+k], k % 4); end
         if (k > 0) begin
            checks++; if (pop_cyc[p0+k] - pop_cyc[p0+k-1] != 3) begin fails++; $display("FAIL rot_gap%0d: got %0d cycles want 3", k, pop_cyc[p0+k] - pop_cyc[p0+k-1]); end
         end
         checks++; if (push_lit[q0+k] !== 16'(40 + k)) begin fails++; $display("FAIL rot_uc%0d: got %0d want %0d", k, push_lit[q0+k], 40 + k); end
      end
      checks++; if (bcast_cnt !== 16'd24) begin fails++; $display("FAIL rot_bcast: got %0d want 24", bcast_cnt); end
   endtask

   task automatic test_drops();
      add_lit(0, 16'd0);
      #1;
      checks++; if (ucq.ucarb2UCQ_in_pop !== 4'b0001) begin fails++; $display("FAIL zero_pop: got %b want 0001", ucq.ucarb2UCQ_in_pop); end
      step();
      step();
      checks++; if (busy !== 1'b0 || drop_cnt !== 16'd2) begin fails++; $display("FAIL zero_drop: busy %b drop %0d want 0/2", busy, drop_cnt); end
      add_lit(1, 16'h8000);
      add_lit(2, 16'd256);
      add_lit(3, -16'sd300);
      wait_idle("range");
      checks++; if (drop_cnt !== 16'd5 || bcast_cnt !== 16'd24) begin fails++; $display("FAIL range_drop: drop %0d bcast %0d want 5/24", drop_cnt, bcast_cnt); end
      add_lit(0, 16'd255);
      wait_idle("maxvar");
      checks++; if (bcast_cnt !== 16'd25 || push_lit[push_n-1] !== 16'd255) begin fails++; $display("FAIL maxvar: bcast %0d uc %0d want 25/255", bcast_cnt, push_lit[push_n-1]); end
   endtask

   task automatic test_reset_mid();
      add_lit(1, 16'd70);
      #1;
      checks++; if (ucq.ucarb2UCQ_in_pop !== 4'b0010) begin fails++; $display("FAIL rmid_pop: got %b want 0010", ucq.ucarb2UCQ_in_pop); end
      step();
      step();
      checks++; if (ucq.ucarb2UCQ_out_push !== 4'b1111) begin fails++; $display("FAIL rmid_bcast: got %b want 1111", ucq.ucarb2UCQ_out_push); end
      rst_n = 1'b0;
      #1;
      checks++; if (ucq.ucarb2UCQ_out_push !== 4'b0000 || ucq.ucarb2UCQ_out_uc !== 16'd0) begin fails++; $display("FAIL rmid_push_drop: push %b uc %h want 0000/0000", ucq.ucarb2UCQ_out_push, ucq.ucarb2UCQ_out_uc); end
      checks++; if (bcast_cnt !== 16'd0 || drop_cnt !== 16'd0 || conflict !== 1'b0) begin fails++; $display("FAIL rmid_state: bcast %0d drop %0d conflict %b want 0/0/0", bcast_cnt, drop_cnt, conflict); end
      step();
      rst_n = 1'b1;
      step();
      checks++; if (push_n == 0 || push_lit[push_n-1] !== 16'd255) begin fails++; $display("FAIL rmid_lost: last push %0d want 255 (70 never pushed)", push_lit[push_n-1]); end
      add_lit(2, -16'sd70);
      wait_idle("rmid_table");
      checks++; if (conflict !== 1'b0 || bcast_cnt !== 16'd1) begin fails++; $display("FAIL rmid_table: conflict %b bcast %0d want 0/1", conflict, bcast_cnt); end
      checks++; if (push_lit[push_n-1] !== 16'hFFBA) begin fails++; $display("FAIL rmid_uc: got %h want ffba", push_lit[push_n-1]); end
   endtask

   initial begin
      test_reset();
      test_single();
      test_dup_rr();
      test_conflict();
      test_backpressure();
      test_rotation();
      test_drops();
      test_reset_mid();
      $display("%0d/%0d checks passed", checks - fails, checks);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL global_timeout: simulation still running at %0t, required completion", $time);
      $fatal(1);
   end
endmodule
